// File: rtl/ball_motion_ctrl_if.sv
// rtl/ball_motion_ctrl_if.sv - control strobes in, ball state out for the Pong ball engine
interface ball_motion_ctrl_if #(
  parameter int W  = 6,
  parameter int VW = 3
);
  logic          tick;
  logic          start;
  logic          paddle_hit_l;
  logic          paddle_hit_r;
  logic [W-1:0]  bx_o;
  logic [W-1:0]  by_o;
  logic          dx_neg;
  logic          dy_neg;
  logic [VW-1:0] vx_o;
  logic          in_play;
  logic          score_p1;
  logic          score_p2;

  modport slave (
    input  tick, start, paddle_hit_l, paddle_hit_r,
    output bx_o, by_o, dx_neg, dy_neg, vx_o, in_play, score_p1, score_p2
  );

  modport master (
    output tick, start, paddle_hit_l, paddle_hit_r,
    input  bx_o, by_o, dx_neg, dy_neg, vx_o, in_play, score_p1, score_p2
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - Pong ball engine: serve, wall/paddle reflection, miss scoring
module ball_motion_ctrl #(
  parameter int         W           = 6,
  parameter int         FIELD_MAX   = 63,
  parameter int         CENTER      = 31,
  parameter int         VW          = 3,
  parameter int         SPEED_INIT  = 2,
  parameter int         VMAX        = 7,
  parameter int         SERVE_DELAY = 16,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  ball_motion_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_MOVE, S_SCORED} state_t;

  // Serve counter only needs to reach SERVE_DELAY-1; the final tick moves on.
  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [CW-1:0]        CNT_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [W-1:0]         CENTER_V = W'(CENTER);
  localparam logic [W-1:0]         FMAX_V   = W'(FIELD_MAX);
  localparam logic [VW-1:0]        SPEED_V  = VW'(SPEED_INIT);
  localparam logic [VW-1:0]        VMAX_V   = VW'(VMAX);
  localparam logic signed [W+1:0]  FMAX_S   = (W+2)'(FIELD_MAX);
  localparam logic signed [W+1:0]  FMAX2_S  = (W+2)'(2 * FIELD_MAX);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   bx_q, bx_d, by_q, by_d;
  logic           dx_q, dx_d, dy_q, dy_d;
  logic [VW-1:0]  vx_q, vx_d;
  logic [1:0]     vy_q, vy_d;
  logic           first_q, first_d;
  logic           sp1_q, sp1_d, sp2_q, sp2_d;
  logic [7:0]     lfsr_q;

  // Candidate positions and their reflections, all in signed W+2 bits so
  // overshoot past either edge stays representable.
  logic signed [W+1:0] bx_s, by_s, vx_s, vy_s;
  logic signed [W+1:0] nx, ny, x_lo, x_hi, y_lo, y_hi;
  logic [VW-1:0]       vx_inc;

  // Free-running Fibonacci LFSR (taps 8,6,5,4) used to randomise serves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // State and ball registers; reset aborts any rally without scoring
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bx_q    <= CENTER_V;
      by_q    <= CENTER_V;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      vx_q    <= SPEED_V;
      vy_q    <= 2'd1;
      first_q <= 1'b1;
      sp1_q   <= 1'b0;
      sp2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      first_q <= first_d;
      sp1_q   <= sp1_d;
      sp2_q   <= sp2_d;
    end
  end

  // Next-state and datapath: serve countdown, per-tick motion, reflection, miss detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    first_d = first_q;
    sp1_d   = 1'b0;
    sp2_d   = 1'b0;

    bx_s   = $signed({2'b00, bx_q});
    by_s   = $signed({2'b00, by_q});
    vx_s   = $signed({{(W+2-VW){1'b0}}, vx_q});
    vy_s   = $signed({{W{1'b0}}, vy_q});
    nx     = dx_q ? (bx_s - vx_s) : (bx_s + vx_s);
    ny     = dy_q ? (by_s - vy_s) : (by_s + vy_s);
    x_lo   = -nx;
    x_hi   = FMAX2_S - nx;
    y_lo   = -ny;
    y_hi   = FMAX2_S - ny;
    vx_inc = (vx_q >= VMAX_V) ? VMAX_V : (vx_q + 1'b1);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SERVE;
          cnt_d   = '0;
        end
      end

      S_SERVE: begin
        if (bus.tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_MOVE;
            cnt_d   = '0;
            bx_d    = CENTER_V;
            by_d    = CENTER_V;
            vx_d    = SPEED_V;
            vy_d    = lfsr_q[1] ? 2'd2 : 2'd1;
            dy_d    = lfsr_q[2];
            // A miss leaves dx pointing at the losing side, which is exactly
            // the direction the next serve must travel.
            dx_d    = first_q ? lfsr_q[0] : dx_q;
            first_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_MOVE: begin
        if (bus.tick) begin
          if (ny < 0) begin
            by_d = W'(y_lo);
            dy_d = 1'b0;
          end else if (ny > FMAX_S) begin
            by_d = W'(y_hi);
            dy_d = 1'b1;
          end else begin
            by_d = W'(ny);
          end

          if (dx_q && (nx <= 0)) begin
            if (bus.paddle_hit_l) begin
              bx_d = W'(x_lo);
              dx_d = 1'b0;
              vx_d = vx_inc;
            end else begin
              bx_d    = '0;
              state_d = S_SCORED;
              sp2_d   = 1'b1;
            end
          end else if (!dx_q && (nx >= FMAX_S)) begin
            if (bus.paddle_hit_r) begin
              bx_d = W'(x_hi);
              dx_d = 1'b1;
              vx_d = vx_inc;
            end else begin
              bx_d    = FMAX_V;
              state_d = S_SCORED;
              sp1_d   = 1'b1;
            end
          end else begin
            bx_d = W'(nx);
          end
        end
      end

      S_SCORED: begin
        state_d = S_SERVE;
        cnt_d   = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.bx_o     = bx_q;
  assign bus.by_o     = by_q;
  assign bus.dx_neg   = dx_q;
  assign bus.dy_neg   = dy_q;
  assign bus.vx_o     = vx_q;
  assign bus.in_play  = (state_q == S_MOVE);
  assign bus.score_p1 = sp1_q;
  assign bus.score_p2 = sp2_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - randomized self-checking bench for ball_motion_ctrl
module tb_ball_motion_ctrl;

  localparam int SD = 4;
  localparam int FM = 63;
  localparam int MID = 31;
  localparam int TOP_SPEED = 7;

  localparam int M_IDLE = 0, M_SERVE = 1, M_MOVE = 2, M_SCORED = 3;

  logic clk;
  logic reset;

  ball_motion_ctrl_if #(.W(6), .VW(3)) bus ();

  ball_motion_ctrl #(.SERVE_DELAY(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model of the game, kept in plain integers
  int       m_mode, m_x, m_y, m_vx, m_vy, m_wait;
  bit       m_left, m_up, m_first, m_last_p2, m_p1, m_p2;
  bit [7:0] m_lfsr;

  int cov_sat, cov_p1, cov_p2, cov_wall, cov_hit, cov_rst_move;

  task automatic chk(input string tag, input string fld, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s.%s got=%0d expected=%0d", tag, fld, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "bx",       bus.bx_o,     m_x);
    chk(tag, "by",       bus.by_o,     m_y);
    chk(tag, "dx_neg",   bus.dx_neg,   m_left);
    chk(tag, "dy_neg",   bus.dy_neg,   m_up);
    chk(tag, "vx",       bus.vx_o,     m_vx);
    chk(tag, "in_play",  bus.in_play,  (m_mode == M_MOVE));
    chk(tag, "score_p1", bus.score_p1, m_p1);
    chk(tag, "score_p2", bus.score_p2, m_p2);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_x = MID; m_y = MID; m_vx = 2; m_vy = 1; m_wait = 0;
    m_left = 0; m_up = 0; m_first = 1; m_last_p2 = 0; m_p1 = 0; m_p2 = 0;
    m_lfsr = 8'hA5;
  endtask

  task automatic model_edge(input bit t, input bit s, input bit hl, input bit hr);
    int nx, ny;
    bit [7:0] l;
    l = m_lfsr;
    m_p1 = 0;
    m_p2 = 0;
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_SERVE; m_wait = 0; end
      M_SERVE: if (t) begin
        m_wait++;
        if (m_wait == SD) begin
          m_x = MID; m_y = MID; m_vx = 2; m_vy = 1 + l[1]; m_up = l[2];
          m_left = m_first ? l[0] : m_last_p2;
          m_first = 0;
          m_mode = M_MOVE;
        end
      end
      M_MOVE: if (t) begin
        nx = m_x + (m_left ? -m_vx : m_vx);
        ny = m_y + (m_up ? -m_vy : m_vy);
        if (ny < 0) begin m_y = -ny; m_up = 0; cov_wall++; end
        else if (ny > FM) begin m_y = 2*FM - ny; m_up = 1; cov_wall++; end
        else m_y = ny;
        if (m_left && nx <= 0) begin
          if (hl) begin
            if (m_vx == TOP_SPEED) cov_sat++;
            m_x = -nx; m_left = 0; m_vx = (m_vx < TOP_SPEED) ? m_vx + 1 : TOP_SPEED; cov_hit++;
          end else begin
            m_x = 0; m_mode = M_SCORED; m_p2 = 1; m_last_p2 = 1; cov_p2++;
          end
        end else if (!m_left && nx >= FM) begin
          if (hr) begin
            if (m_vx == TOP_SPEED) cov_sat++;
            m_x = 2*FM - nx; m_left = 1; m_vx = (m_vx < TOP_SPEED) ? m_vx + 1 : TOP_SPEED; cov_hit++;
          end else begin
            m_x = FM; m_mode = M_SCORED; m_p1 = 1; m_last_p2 = 0; cov_p1++;
          end
        end else begin
          m_x = nx;
        end
      end
      M_SCORED: begin m_mode = M_SERVE; m_wait = 0; end
      default: m_mode = M_IDLE;
    endcase
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  // one clock cycle: drive inputs, let the edge happen, advance model, compare
  task automatic cyc(input string tag, input bit t, input bit s, input bit hl, input bit hr);
    bus.tick = t; bus.start = s; bus.paddle_hit_l = hl; bus.paddle_hit_r = hr;
    @(posedge clk);
    model_edge(t, s, hl, hr);
    #1;
    check_all(tag);
  endtask

  // asynchronous reset asserted between edges, held across one edge
  task automatic do_reset(input string tag);
    bus.tick = 0; bus.start = 0; bus.paddle_hit_l = 0; bus.paddle_hit_r = 0;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    cov_sat = 0; cov_p1 = 0; cov_p2 = 0; cov_wall = 0; cov_hit = 0; cov_rst_move = 0;
    reset = 1'b0;
    bus.tick = 0; bus.start = 0; bus.paddle_hit_l = 0; bus.paddle_hit_r = 0;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // idle: ticks and paddle pulses must not disturb anything
    for (int i = 0; i < 6; i++)
      cyc("idle", 1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));

    // start, then serve with stray start/paddle pulses and four ticks
    cyc("start", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc("serve", (i % 2 == 0), 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    chk("first_serve", "in_play", bus.in_play, 1);
    chk("first_serve", "bx",      bus.bx_o,    MID);
    chk("first_serve", "by",      bus.by_o,    MID);
    chk("first_serve", "vx",      bus.vx_o,    2);

    // a few moves, then reset between ticks; start is then required again
    for (int i = 0; i < 5; i++) cyc("move", 1'b1, 1'b0, 1'b1, 1'b1);
    do_reset("rst_mid_move");
    cov_rst_move++;
    for (int i = 0; i < 6; i++) cyc("post_rst_idle", 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("restart", 1'b0, 1'b1, 1'b0, 1'b0);

    // long randomized rally with occasional mid-play resets
    for (int i = 0; i < 9000; i++) begin
      if (m_mode == M_MOVE && $urandom_range(1499) == 0) begin
        do_reset("rst_rand");
        cov_rst_move++;
      end else begin
        cyc("rand", ($urandom_range(3) != 0), ($urandom_range(7) == 0),
            ($urandom_range(7) != 0), ($urandom_range(7) != 0));
      end
    end

    chk("cover", "speed_cap_hit", (cov_sat > 0), 1);
    chk("cover", "score_p1_seen", (cov_p1 > 0), 1);
    chk("cover", "score_p2_seen", (cov_p2 > 0), 1);
    chk("cover", "wall_bounce",   (cov_wall > 0), 1);
    chk("cover", "paddle_bounce", (cov_hit > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
